io_mmio_controller: RTL

- Sequences CPU accesses to the memory-mapped IO region (A[31:28] = 4'b1000).
- Driven by the memory decoder's Io_trans byte enables and Io_recv strobe.
- Owns a one-byte UART transmit holding buffer, a one-byte receive buffer with ready/valid handshakes to the UART, and free-running cycle and retired-instruction counters.
- Returns registered read data, one cycle after the access, aligned with synchronous dmem reads in the pipeline's memory/writeback stage.

---
 rtl/io_mmio_controller_pkg.sv | 18 +
 rtl/io_counter.sv | 26 ++
 rtl/io_mmio_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/io_mmio_controller_pkg.sv
// rtl/io_mmio_controller_pkg.sv - shared constants and types for the IO MMIO controller
package io_mmio_controller_pkg;

  localparam logic [3:0] IO_REGION    = 4'b1000;

  localparam logic [7:0] IO_STATUS    = 8'h00;
  localparam logic [7:0] IO_RX_DATA   = 8'h04;
  localparam logic [7:0] IO_TX_DATA   = 8'h08;
  localparam logic [7:0] IO_CYCLE_CNT = 8'h10;
  localparam logic [7:0] IO_INST_CNT  = 8'h14;
  localparam logic [7:0] IO_CNT_RST   = 8'h18;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/io_counter.sv
// rtl/io_counter.sv - wrapping counter with enable and synchronous clear (clear wins)
module io_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/io_mmio_controller.sv
// rtl/io_mmio_controller.sv - MMIO register block: UART tx/rx byte buffers and cycle/instret counters
module io_mmio_controller
  import io_mmio_controller_pkg::*;
#(
  parameter int CNT_WIDTH     = 32,
  parameter int ADDR_LSB_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  io_trans,
  input  logic        io_recv,
  input  logic        inst_retired,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  tx_state_e r_tx_state;
  tx_state_e w_tx_next;
  logic [7:0]  r_tx_buf;
  logic [7:0]  r_rx_buf;
  logic        r_rx_full;
  logic [31:0] r_rdata;
  logic [31:0] w_rdata_nxt;

  logic                     w_in_region;
  logic [ADDR_LSB_BITS-1:0] w_off;
  logic                     w_load;
  logic                     w_store;
  logic                     w_tx_wr;
  logic                     w_rx_rd;
  logic                     w_rx_accept;
  logic                     w_cnt_clr;
  logic [CNT_WIDTH-1:0]     w_cycle_cnt;
  logic [CNT_WIDTH-1:0]     w_inst_cnt;
  logic                     w_unused;

  assign w_in_region = (addr[31:28] == IO_REGION);
  assign w_off       = addr[ADDR_LSB_BITS-1:0];
  assign w_load      = io_recv & ~stall & w_in_region;
  assign w_store     = (io_trans != 4'b0000) & ~stall & w_in_region;

  assign w_tx_wr     = w_store & io_trans[0] & (w_off == ADDR_LSB_BITS'(IO_TX_DATA));
  assign w_rx_rd     = w_load & (w_off == ADDR_LSB_BITS'(IO_RX_DATA));
  assign w_cnt_clr   = w_store & (w_off == ADDR_LSB_BITS'(IO_CNT_RST));
  assign w_rx_accept = uart_rx_valid & ~r_rx_full;

  assign w_unused    = &{1'b0, wdata[31:8], addr[27:ADDR_LSB_BITS]};

  io_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (w_cnt_clr),
    .count (w_cycle_cnt)
  );

  io_counter #(.WIDTH(CNT_WIDTH)) u_inst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (inst_retired),
    .clr   (w_cnt_clr),
    .count (w_inst_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_EMPTY;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  // A store arriving while full is dropped even if the handshake completes that cycle.
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_EMPTY: if (w_tx_wr)       w_tx_next = TX_FULL;
      TX_FULL:  if (uart_tx_ready) w_tx_next = TX_EMPTY;
      default:                     w_tx_next = TX_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_buf <= 8'h00;
    end else if (r_tx_state == TX_EMPTY && w_tx_wr) begin
      r_tx_buf <= wdata[7:0];
    end
  end

  // rx_ready depends only on rx_full, so a consume and a refill never share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_full <= 1'b0;
      r_rx_buf  <= 8'h00;
    end else if (w_rx_accept) begin
      r_rx_full <= 1'b1;
      r_rx_buf  <= uart_rx_data;
    end else if (w_rx_rd) begin
      r_rx_full <= 1'b0;
    end
  end

  always_comb begin
    w_rdata_nxt = 32'h0;
    case (w_off)
      ADDR_LSB_BITS'(IO_STATUS):    w_rdata_nxt = {30'h0, r_rx_full, (r_tx_state == TX_EMPTY)};
      ADDR_LSB_BITS'(IO_RX_DATA):   w_rdata_nxt = {24'h0, r_rx_buf};
      ADDR_LSB_BITS'(IO_CYCLE_CNT): w_rdata_nxt = 32'(w_cycle_cnt);
      ADDR_LSB_BITS'(IO_INST_CNT):  w_rdata_nxt = 32'(w_inst_cnt);
      default:                      w_rdata_nxt = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'h0;
    end else if (w_load) begin
      r_rdata <= w_rdata_nxt;
    end
  end

  assign rdata         = r_rdata;
  assign uart_tx_data  = r_tx_buf;
  assign uart_tx_valid = (r_tx_state == TX_FULL);
  assign uart_rx_ready = ~r_rx_full;

endmodule
